// File: rtl/mem_arbiter_2p_pkg.sv
// Shared widths, state encoding, port indices and command payload for the two-port memory arbiter.
package mem_arbiter_2p_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Port 1 keeps the favour while it holds its burst lock; otherwise hand it to the other port.
    function automatic logic next_rr_ptr(input logic owner, input logic lock1);
        return (owner == PORT_LDR && lock1) ? PORT_LDR : ~owner;
    endfunction

endpackage

// File: rtl/mem_arbiter_2p_if.sv
// Requester and memory-side signal bundle of the two-port memory arbiter.
interface mem_arbiter_2p_if;
    import mem_arbiter_2p_pkg::*;

    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              lock1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_d_i;
    logic [DATA_W-1:0] mem_d_o;

    // Requesters and the memory model sit on the master side.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_d_o,
        input  ack0, ack1, rdata0, rdata1, busy, mem_we, mem_addr, mem_d_i
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_d_o,
        output ack0, ack1, rdata0, rdata1, busy, mem_we, mem_addr, mem_d_i
    );

endinterface

// File: rtl/mem_arbiter_2p_rr_arb2.sv
// Combinational two-way picker: round-robin on rr_ptr or fixed priority to port 0.
module rr_arb2
    import mem_arbiter_2p_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    input  logic rr_en,
    output logic grant_c,
    output logic valid_c
);

    always_comb begin
        valid_c = req0 | req1;
        grant_c = PORT_CPU;
        if (req0 && req1) begin
            grant_c = rr_en ? rr_ptr : PORT_CPU;
        end else if (req1) begin
            grant_c = PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter_2p.sv
// Shares one single-port memory between a CPU port and a loader port; three cycles per access.
module mem_arbiter_2p
    import mem_arbiter_2p_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    mem_arbiter_2p_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;
    mem_cmd_t          cmd_q, cmd_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              busy_q, busy_d;
    logic              grant_c, grant_valid_c;

    rr_arb2 u_rr_arb2 (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .rr_ptr  (rr_ptr_q),
        .rr_en   (1'(RR_EN)),
        .grant_c (grant_c),
        .valid_c (grant_valid_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= PORT_CPU;
            rr_ptr_q <= PORT_CPU;
            cmd_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cmd_q    <= cmd_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    // Write enable is a single-cycle strobe: cleared by default, only set when a command is captured.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cmd_d    = cmd_q;
        cmd_d.we = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        busy_d   = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    owner_d = grant_c;
                    cmd_d   = (grant_c == PORT_LDR)
                            ? mem_cmd_t'{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1}
                            : mem_cmd_t'{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
                    busy_d  = 1'b1;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!cmd_q.we) begin
                    if (owner_q == PORT_LDR) rdata1_d = bus.mem_d_o;
                    else                     rdata0_d = bus.mem_d_o;
                end
                ack0_d  = (owner_q == PORT_CPU);
                ack1_d  = (owner_q == PORT_LDR);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rr_ptr_d = next_rr_ptr(owner_q, bus.lock1);
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.busy     = busy_q;
    assign bus.mem_we   = cmd_q.we;
    assign bus.mem_addr = cmd_q.addr;
    assign bus.mem_d_i  = cmd_q.wdata;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Bench for mem_arbiter_2p: round-robin and fixed-priority instances, each behind a preloaded memory.
module tb_mem_arbiter_2p;
    import mem_arbiter_2p_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_2p_if rr_if ();
    mem_arbiter_2p_if fp_if ();

    mem_arbiter_2p #(.RR_EN(1'b1)) u_rr (.clk(clk), .rst_n(rst_n), .bus(rr_if.slave));
    mem_arbiter_2p #(.RR_EN(1'b0)) u_fp (.clk(clk), .rst_n(rst_n), .bus(fp_if.slave));

    function automatic logic [7:0] image(input int a);
        case (a)
            0:       return 8'h64;
            1:       return 8'h10;
            2:       return 8'h93;
            4:       return 8'hFF;
            default: return 8'(a * 37 + 5);
        endcase
    endfunction

    // Memory stand-ins: combinational read, write on rising edge, image loaded on first edge.
    logic [7:0] mem_rr [256];
    logic [7:0] mem_fp [256];
    logic       loaded = 1'b0;
    assign rr_if.mem_d_o = mem_rr[rr_if.mem_addr];
    assign fp_if.mem_d_o = mem_fp[fp_if.mem_addr];
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) begin
                mem_rr[i] <= image(i);
                mem_fp[i] <= image(i);
            end
            loaded <= 1'b1;
        end else begin
            if (rr_if.mem_we) mem_rr[rr_if.mem_addr] <= rr_if.mem_d_i;
            if (fp_if.mem_we) mem_fp[fp_if.mem_addr] <= fp_if.mem_d_i;
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else             n_pass++;
    endtask

    // Transaction-level reference for the round-robin instance.
    mem_cmd_t   q0[$], q1[$];
    logic       lock1 = 1'b0;
    logic [7:0] model_mem [256];
    int         m_slot  = 0;      // 0 free, 1 memory cycle, 2 response cycle
    logic       m_owner = 1'b0;
    logic       m_fav   = 1'b0;   // port favoured on the next contended pick
    mem_cmd_t   m_cmd;
    logic [7:0] m_rd [2];
    int         ack_log[$];

    task automatic drive_reqs();
        rr_if.req0 = (q0.size() != 0);
        if (q0.size() != 0) begin
            rr_if.we0 = q0[0].we; rr_if.addr0 = q0[0].addr; rr_if.wdata0 = q0[0].wdata;
        end
        rr_if.req1 = (q1.size() != 0);
        if (q1.size() != 0) begin
            rr_if.we1 = q1[0].we; rr_if.addr1 = q1[0].addr; rr_if.wdata1 = q1[0].wdata;
        end
        rr_if.lock1 = lock1;
    endtask

    task automatic model_reset();
        m_slot = 0; m_owner = 1'b0; m_fav = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00;
    endtask

    task automatic step();
        logic win;
        @(posedge clk);
        case (m_slot)
            0: if (rr_if.req0 || rr_if.req1) begin
                win     = (rr_if.req0 && rr_if.req1) ? m_fav : rr_if.req1;
                m_owner = win;
                m_cmd   = win ? mem_cmd_t'{we: rr_if.we1, addr: rr_if.addr1, wdata: rr_if.wdata1}
                              : mem_cmd_t'{we: rr_if.we0, addr: rr_if.addr0, wdata: rr_if.wdata0};
                m_slot  = 1;
            end
            1: begin
                if (m_cmd.we) model_mem[m_cmd.addr] = m_cmd.wdata;
                else          m_rd[m_owner] = model_mem[m_cmd.addr];
                m_slot = 2;
            end
            default: begin
                m_fav  = (m_owner && rr_if.lock1) ? 1'b1 : !m_owner;
                m_slot = 0;
            end
        endcase
        #1;
        check("busy",   32'(rr_if.busy),   32'(m_slot != 0));
        check("ack0",   32'(rr_if.ack0),   32'(m_slot == 2 && !m_owner));
        check("ack1",   32'(rr_if.ack1),   32'(m_slot == 2 && m_owner));
        check("mem_we", 32'(rr_if.mem_we), 32'(m_slot == 1 && m_cmd.we));
        check("rdata0", 32'(rr_if.rdata0), 32'(m_rd[0]));
        check("rdata1", 32'(rr_if.rdata1), 32'(m_rd[1]));
        if (m_slot == 2) begin
            ack_log.push_back(int'(m_owner));
            if (m_owner) begin if (q1.size() != 0) void'(q1.pop_front()); end
            else         begin if (q0.size() != 0) void'(q0.pop_front()); end
        end
        drive_reqs();
    endtask

    task automatic run_until_idle(input int budget, input bool_drop_lock);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_slot != 0) && n < budget) begin
            step();
            if (bool_drop_lock && q1.size() == 0) lock1 = 1'b0;
            n++;
        end
        if (n >= budget) check("idle_timeout", 32'(n), 32'(budget - 1));
    endtask

    function automatic mem_cmd_t rd(input logic [7:0] a);
        return mem_cmd_t'{we: 1'b0, addr: a, wdata: 8'h00};
    endfunction

    function automatic mem_cmd_t rand_cmd();
        mem_cmd_t c;
        c.we    = 1'($urandom_range(0, 1));
        c.addr  = 8'(16 + $urandom_range(0, 7));
        c.wdata = 8'($urandom);
        return c;
    endfunction

    initial begin
        int n0, n1;
        for (int i = 0; i < 256; i++) model_mem[i] = image(i);
        model_reset();
        lock1 = 1'b0;
        drive_reqs();
        rr_if.we0 = 0; rr_if.we1 = 0; rr_if.addr0 = 0; rr_if.addr1 = 0;
        rr_if.wdata0 = 0; rr_if.wdata1 = 0;
        fp_if.req0 = 0; fp_if.req1 = 0; fp_if.we0 = 0; fp_if.we1 = 0; fp_if.lock1 = 0;
        fp_if.addr0 = 0; fp_if.addr1 = 0; fp_if.wdata0 = 0; fp_if.wdata1 = 0;

        // Reset held three cycles: every output at zero.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0",  32'(rr_if.ack0),     0);
        check("rst_ack1",  32'(rr_if.ack1),     0);
        check("rst_rd0",   32'(rr_if.rdata0),   0);
        check("rst_rd1",   32'(rr_if.rdata1),   0);
        check("rst_busy",  32'(rr_if.busy),     0);
        check("rst_we",    32'(rr_if.mem_we),   0);
        check("rst_addr",  32'(rr_if.mem_addr), 0);
        check("rst_di",    32'(rr_if.mem_d_i),  0);
        check("rst_fp_we", 32'(fp_if.mem_we),   0);
        rst_n = 1'b1;
        repeat (3) step();

        // Port 0 reads of preloaded locations.
        q0.push_back(rd(8'h00)); drive_reqs();
        run_until_idle(20, 1'b0);
        check("t2_rd00", 32'(rr_if.rdata0), 32'h64);
        q0.push_back(rd(8'h04)); drive_reqs();
        run_until_idle(20, 1'b0);
        check("t2_rd04", 32'(rr_if.rdata0), 32'hFF);

        // Port 1 write, port 0 read-back; port 1 read data untouched by writes.
        q1.push_back(mem_cmd_t'{we: 1'b1, addr: 8'h05, wdata: 8'hA5}); drive_reqs();
        run_until_idle(20, 1'b0);
        q0.push_back(rd(8'h05)); drive_reqs();
        run_until_idle(20, 1'b0);
        check("t3_rd05", 32'(rr_if.rdata0), 32'hA5);
        check("t3_rd1",  32'(rr_if.rdata1), 32'h00);

        // Both ports contend: grants alternate.
        ack_log.delete();
        repeat (4) begin q0.push_back(rd(8'h01)); q1.push_back(rd(8'h01)); end
        drive_reqs();
        run_until_idle(60, 1'b0);
        check("t4_nacks", 32'(ack_log.size()), 8);
        for (int i = 1; i < ack_log.size(); i++)
            check("t4_alternate", 32'(ack_log[i] != ack_log[i-1]), 1);
        check("t4_rd0", 32'(rr_if.rdata0), 32'h10);
        check("t4_rd1", 32'(rr_if.rdata1), 32'h10);

        // Burst lock keeps port 1 in front until it drops the lock.
        ack_log.delete();
        lock1 = 1'b1;
        repeat (4) q1.push_back(rd(8'h01));
        q0.push_back(rd(8'h01));
        drive_reqs();
        run_until_idle(60, 1'b1);
        lock1 = 1'b0; drive_reqs();
        check("t4_lock_n", 32'(ack_log.size()), 5);
        for (int i = 0; i < 4; i++) check("t4_lock_p1", 32'(ack_log[i]), 1);
        check("t4_lock_p0", 32'(ack_log[4]), 0);

        // Fixed priority: port 1 starves while port 0 keeps requesting.
        fp_if.addr0 = 8'h01; fp_if.addr1 = 8'h01;
        fp_if.req0 = 1'b1; fp_if.req1 = 1'b1;
        n0 = 0; n1 = 0;
        repeat (12) begin
            @(posedge clk); #1;
            n0 += int'(fp_if.ack0);
            n1 += int'(fp_if.ack1);
            check("t5_ack1_low", 32'(fp_if.ack1), 0);
        end
        check("t5_n_ack0", 32'(n0), 4);
        check("t5_n_ack1", 32'(n1), 0);
        check("t5_rd0",    32'(fp_if.rdata0), 32'h10);
        check("t5_rd1",    32'(fp_if.rdata1), 32'h00);
        fp_if.req0 = 1'b0; fp_if.req1 = 1'b0;
        repeat (3) step();

        // Reset during the memory cycle of a write: strobe drops at once, write lost.
        q1.push_back(mem_cmd_t'{we: 1'b1, addr: 8'h02, wdata: 8'h00}); drive_reqs();
        step();
        check("t6_we_pre", 32'(rr_if.mem_we), 1);
        rst_n = 1'b0;
        #1;
        check("t6_we_async", 32'(rr_if.mem_we), 0);
        check("t6_busy",     32'(rr_if.busy),   0);
        check("t6_ack1",     32'(rr_if.ack1),   0);
        q1.delete(); model_reset(); drive_reqs();
        repeat (2) @(posedge clk);
        #2;
        check("t6_ack1_rst", 32'(rr_if.ack1), 0);
        rst_n = 1'b1;
        q0.push_back(rd(8'h02)); drive_reqs();
        run_until_idle(20, 1'b0);
        check("t6_rd02", 32'(rr_if.rdata0), 32'h93);

        // Random mixed traffic against the reference.
        repeat (300) begin
            if (q0.size() < 2 && $urandom_range(0, 1) == 1) q0.push_back(rand_cmd());
            if (q1.size() < 2 && $urandom_range(0, 1) == 1) q1.push_back(rand_cmd());
            lock1 = ($urandom_range(0, 4) == 0);
            step();
        end
        lock1 = 1'b0; drive_reqs();
        run_until_idle(60, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
